// File: rtl/common.sv
// Shared Memory-stage types: pipeline records, control fields, access sizes and FSM states.
package common;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 64;

   typedef logic [2:0] msize_t;
   localparam msize_t MSIZE_B = 3'd0;
   localparam msize_t MSIZE_H = 3'd1;
   localparam msize_t MSIZE_W = 3'd2;
   localparam msize_t MSIZE_D = 3'd3;

   typedef struct packed {
      logic   memread;
      logic   memwrite;
      msize_t msize;
      logic   msign;
   } control_t;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] srcb;
      logic [63:0]       pc;
      control_t          ctl;
      logic [4:0]        dst;
      logic              is_bubble;
   } execute_data_t;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [63:0]       pc;
      control_t          ctl;
      logic [4:0]        dst;
      logic              is_bubble;
   } memory_data_t;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;
endpackage

// File: rtl/mem_lane_ext.sv
// Byte-lane steering for stores and lane extraction / extension for loads, plus alignment check.
module mem_lane_ext
   import common::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      addrLo,
   input  msize_t          msize,
   input  logic            msign,
   input  logic [XLEN-1:0] srcb,
   input  logic [XLEN-1:0] rdata,
   output logic [7:0]      strobe,
   output logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] loadVal,
   output logic            misalign
);
   logic [XLEN-1:0] shifted;
   logic [7:0]      byteMask;

   assign shifted = rdata >> {addrLo, 3'b000};
   assign wdata   = srcb << {addrLo, 3'b000};
   assign strobe  = byteMask << addrLo;

   // Sizes above a doubleword are treated as a full doubleword.
   always_comb begin
      byteMask = 8'hFF;
      misalign = |addrLo;
      loadVal  = shifted;
      case (msize)
         MSIZE_B: begin
            byteMask = 8'h01;
            misalign = 1'b0;
            loadVal  = {{(XLEN-8){msign & shifted[7]}}, shifted[7:0]};
         end
         MSIZE_H: begin
            byteMask = 8'h03;
            misalign = addrLo[0];
            loadVal  = {{(XLEN-16){msign & shifted[15]}}, shifted[15:0]};
         end
         MSIZE_W: begin
            byteMask = 8'h0F;
            misalign = |addrLo[1:0];
            loadVal  = {{(XLEN-32){msign & shifted[31]}}, shifted[31:0]};
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: turns E/M loads/stores into valid/addr_ok/data_ok bus transactions and
// produces the reg_MW record plus the stalldata hold/bubble signal.
module mem_access_stage
   import common::*;
#(
   parameter int XLEN = 64,
   parameter int AW   = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  execute_data_t   dataE_in,
   output memory_data_t    dataM_out,
   output logic            stalldata,
   output logic            dreq_valid,
   output logic [AW-1:0]   dreq_addr,
   output logic [2:0]      dreq_size,
   output logic [7:0]      dreq_strobe,
   output logic [XLEN-1:0] dreq_data,
   input  logic            dresp_addr_ok,
   input  logic            dresp_data_ok,
   input  logic [XLEN-1:0] dresp_data,
   output logic            misalign
);
   mem_state_t      state, nextState;
   logic            mem, misal, complete;
   logic [7:0]      strobe;
   logic [XLEN-1:0] wdata, loadVal;

   assign mem = !dataE_in.is_bubble && (dataE_in.ctl.memread || dataE_in.ctl.memwrite);

   mem_lane_ext #(.XLEN(XLEN)) laneExt (
      .addrLo  (dataE_in.result[2:0]),
      .msize   (dataE_in.ctl.msize),
      .msign   (dataE_in.ctl.msign),
      .srcb    (dataE_in.srcb),
      .rdata   (dresp_data),
      .strobe  (strobe),
      .wdata   (wdata),
      .loadVal (loadVal),
      .misalign(misal)
   );

   // Request fields come straight from the held E/M record, so they stay stable while stalled.
   assign dreq_addr   = dataE_in.result[AW-1:0];
   assign dreq_size   = dataE_in.ctl.msize;
   assign dreq_strobe = dataE_in.ctl.memwrite ? strobe : 8'h00;
   assign dreq_data   = wdata;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState  = state;
      dreq_valid = 1'b0;
      complete   = 1'b0;
      misalign   = 1'b0;
      dataM_out  = '{result: dataE_in.result, pc: dataE_in.pc, ctl: dataE_in.ctl,
                     dst: dataE_in.dst, is_bubble: dataE_in.is_bubble};
      case (state)
         IDLE: begin
            if (mem && misal) begin
               misalign            = 1'b1;
               dataM_out.result    = '0;
               dataM_out.is_bubble = 1'b1;
            end else if (mem) begin
               dreq_valid = 1'b1;
               if (dresp_addr_ok) begin
                  if (dresp_data_ok) complete = 1'b1;
                  else               nextState = WAIT;
               end else begin
                  nextState = REQ;
               end
            end
         end
         REQ: begin
            dreq_valid = 1'b1;
            if (dresp_addr_ok) begin
               if (dresp_data_ok) begin
                  complete  = 1'b1;
                  nextState = IDLE;
               end else begin
                  nextState = WAIT;
               end
            end
         end
         WAIT: begin
            if (dresp_data_ok) begin
               complete  = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
      if (complete && dataE_in.ctl.memread) dataM_out.result = loadVal;
      stalldata = mem && !complete && !misalign;
      // Reset overrides everything combinationally, even mid-transaction.
      if (!reset) begin
         nextState           = IDLE;
         dreq_valid          = 1'b0;
         misalign            = 1'b0;
         stalldata           = 1'b0;
         dataM_out           = '0;
         dataM_out.is_bubble = 1'b1;
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: handshake timing, lane steering, extension, misalign, reset.
module tb_mem_access_stage;
   import common::*;

   logic          clk = 1'b0;
   logic          reset;
   execute_data_t dataE;
   memory_data_t  dataM;
   logic          stalldata, dreqValid, misalign;
   logic [63:0]   dreqAddr, dreqData, drespData;
   logic [2:0]    dreqSize;
   logic [7:0]    dreqStrobe;
   logic          addrOk, dataOk;
   int            nVec = 0;
   int            nErr = 0;

   mem_access_stage dut (
      .clk          (clk),
      .reset        (reset),
      .dataE_in     (dataE),
      .dataM_out    (dataM),
      .stalldata    (stalldata),
      .dreq_valid   (dreqValid),
      .dreq_addr    (dreqAddr),
      .dreq_size    (dreqSize),
      .dreq_strobe  (dreqStrobe),
      .dreq_data    (dreqData),
      .dresp_addr_ok(addrOk),
      .dresp_data_ok(dataOk),
      .dresp_data   (drespData),
      .misalign     (misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic setE(input logic rd, input logic wr, input msize_t sz, input logic sg,
                       input logic [63:0] addr, input logic [63:0] srcb, input logic bub);
      dataE.result    = addr;
      dataE.srcb      = srcb;
      dataE.pc        = 64'h0000_0000_0000_1000;
      dataE.ctl       = '{memread: rd, memwrite: wr, msize: sz, msign: sg};
      dataE.dst       = 5'd7;
      dataE.is_bubble = bub;
   endtask

   task automatic bus(input logic aok, input logic dok, input logic [63:0] rd);
      addrOk    = aok;
      dataOk    = dok;
      drespData = rd;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      setE(1'b1, 1'b0, MSIZE_D, 1'b0, 64'h8000_0010, 64'h0, 1'b0);
      bus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

      // Reset state
      @(negedge clk);
      chk("rst_valid", {63'd0, dreqValid}, 64'd0);
      chk("rst_stall", {63'd0, stalldata}, 64'd0);
      chk("rst_misalign", {63'd0, misalign}, 64'd0);
      chk("rst_bubble", {63'd0, dataM.is_bubble}, 64'd1);
      chk("rst_result", dataM.result, 64'd0);
      chk("rst_pc", dataM.pc, 64'd0);
      nextCycle();
      reset = 1'b1;

      // Same-cycle response load
      setE(1'b1, 1'b0, MSIZE_D, 1'b0, 64'h8000_0010, 64'h0, 1'b0);
      bus(1'b1, 1'b1, 64'h1122_3344_5566_7788);
      @(negedge clk);
      chk("ld0_valid", {63'd0, dreqValid}, 64'd1);
      chk("ld0_addr", dreqAddr, 64'h8000_0010);
      chk("ld0_size", {61'd0, dreqSize}, 64'd3);
      chk("ld0_strobe", {56'd0, dreqStrobe}, 64'd0);
      chk("ld0_stall", {63'd0, stalldata}, 64'd0);
      chk("ld0_result", dataM.result, 64'h1122_3344_5566_7788);
      nextCycle();
      setE(1'b0, 1'b0, MSIZE_D, 1'b0, 64'h55, 64'h0, 1'b0);
      bus(1'b0, 1'b0, 64'h0);
      @(negedge clk);
      chk("ld0_idle_valid", {63'd0, dreqValid}, 64'd0);
      chk("alu_pass_result", dataM.result, 64'h55);
      chk("alu_pass_stall", {63'd0, stalldata}, 64'd0);
      nextCycle();

      // Delayed accept store: addr_ok at cycle 2, data_ok at cycle 4
      setE(1'b0, 1'b1, MSIZE_W, 1'b0, 64'h8000_0004, 64'hDEAD_BEEF, 1'b0);
      for (int c = 0; c <= 4; c++) begin
         bus(c == 2, c == 4, 64'h0);
         @(negedge clk);
         chk($sformatf("sw_valid_c%0d", c), {63'd0, dreqValid}, {63'd0, c <= 2});
         chk($sformatf("sw_stall_c%0d", c), {63'd0, stalldata}, {63'd0, c <= 3});
         if (c <= 2) begin
            chk($sformatf("sw_strobe_c%0d", c), {56'd0, dreqStrobe}, 64'hF0);
            chk($sformatf("sw_data_c%0d", c), dreqData, 64'hDEAD_BEEF_0000_0000);
         end
         if (c == 4) chk("sw_result", dataM.result, 64'h8000_0004);
         nextCycle();
      end

      // Halfword store at offset 6
      setE(1'b0, 1'b1, MSIZE_H, 1'b0, 64'h8000_0006, 64'hABCD, 1'b0);
      bus(1'b1, 1'b1, 64'h0);
      @(negedge clk);
      chk("sh_strobe", {56'd0, dreqStrobe}, 64'hC0);
      chk("sh_data", dreqData, 64'hABCD_0000_0000_0000);
      chk("sh_stall", {63'd0, stalldata}, 64'd0);
      nextCycle();

      // Byte loads at offset 7, signed and unsigned
      setE(1'b1, 1'b0, MSIZE_B, 1'b1, 64'h8000_0007, 64'h0, 1'b0);
      bus(1'b1, 1'b1, 64'h8012_3456_789A_BCDE);
      @(negedge clk);
      chk("lb_result", dataM.result, 64'hFFFF_FFFF_FFFF_FF80);
      nextCycle();
      setE(1'b1, 1'b0, MSIZE_B, 1'b0, 64'h8000_0007, 64'h0, 1'b0);
      @(negedge clk);
      chk("lbu_result", dataM.result, 64'h80);
      nextCycle();

      // Signed word load at offset 0
      setE(1'b1, 1'b0, MSIZE_W, 1'b1, 64'h8000_0000, 64'h0, 1'b0);
      bus(1'b1, 1'b1, 64'h0000_0000_F000_0000);
      @(negedge clk);
      chk("lw_result", dataM.result, 64'hFFFF_FFFF_F000_0000);
      nextCycle();

      // Misaligned word load
      setE(1'b1, 1'b0, MSIZE_W, 1'b1, 64'h8000_0002, 64'h0, 1'b0);
      bus(1'b0, 1'b0, 64'h0);
      @(negedge clk);
      chk("mis_valid", {63'd0, dreqValid}, 64'd0);
      chk("mis_pulse", {63'd0, misalign}, 64'd1);
      chk("mis_bubble", {63'd0, dataM.is_bubble}, 64'd1);
      chk("mis_result", dataM.result, 64'd0);
      chk("mis_stall", {63'd0, stalldata}, 64'd0);
      nextCycle();
      setE(1'b0, 1'b0, MSIZE_D, 1'b0, 64'h0, 64'h0, 1'b1);
      @(negedge clk);
      chk("mis_pulse_end", {63'd0, misalign}, 64'd0);
      nextCycle();

      // Reset while waiting for data_ok
      setE(1'b1, 1'b0, MSIZE_D, 1'b0, 64'h8000_0008, 64'h0, 1'b0);
      bus(1'b1, 1'b0, 64'h0);
      @(negedge clk);
      chk("wt_stall", {63'd0, stalldata}, 64'd1);
      nextCycle();
      reset = 1'b0;
      bus(1'b0, 1'b0, 64'h0);
      @(negedge clk);
      chk("midrst_stall", {63'd0, stalldata}, 64'd0);
      chk("midrst_valid", {63'd0, dreqValid}, 64'd0);
      chk("midrst_bubble", {63'd0, dataM.is_bubble}, 64'd1);
      nextCycle();
      reset = 1'b1;
      setE(1'b0, 1'b0, MSIZE_D, 1'b0, 64'h0, 64'h0, 1'b1);
      bus(1'b0, 1'b1, 64'h0);
      @(negedge clk);
      chk("stray_stall", {63'd0, stalldata}, 64'd0);
      chk("stray_valid", {63'd0, dreqValid}, 64'd0);
      nextCycle();
      setE(1'b1, 1'b0, MSIZE_D, 1'b0, 64'h8000_0018, 64'h0, 1'b0);
      bus(1'b0, 1'b0, 64'h0);
      @(negedge clk);
      chk("post_rst_valid", {63'd0, dreqValid}, 64'd1);
      chk("post_rst_stall", {63'd0, stalldata}, 64'd1);
      nextCycle();
      bus(1'b1, 1'b1, 64'h0102_0304_0506_0708);
      @(negedge clk);
      chk("req_done_valid", {63'd0, dreqValid}, 64'd1);
      chk("req_done_stall", {63'd0, stalldata}, 64'd0);
      chk("req_done_result", dataM.result, 64'h0102_0304_0506_0708);
      nextCycle();

      // Bubble carrying memread
      setE(1'b1, 1'b0, MSIZE_D, 1'b0, 64'h1234, 64'h0, 1'b1);
      bus(1'b0, 1'b0, 64'h0);
      @(negedge clk);
      chk("bub_valid", {63'd0, dreqValid}, 64'd0);
      chk("bub_stall", {63'd0, stalldata}, 64'd0);
      chk("bub_bubble", {63'd0, dataM.is_bubble}, 64'd1);
      chk("bub_result", dataM.result, 64'h1234);
      chk("bub_dst", {59'd0, dataM.dst}, 64'd7);
      nextCycle();

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-stage engine that sits between the Execute/Memory pipeline register and reg_MW. It drives the per-cycle Memory-stage record into reg_MW and generates the `stalldata` hold/bubble signal that reg_MW consumes.
- Converts a load or store carried in the execute record into a data-bus transaction using a valid / addr_ok / data_ok handshake.
- Performs store byte-lane steering, load extraction and load sign/zero extension.

Parameters:
- XLEN, 64, data width of results, store data and bus data.
- AW, 64, bus address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; 0 on a clk edge resets the block.
- dataE_in  in  execute_data_t  record from the E/M register: result (address), srcb (store data), pc, ctl (memread, memwrite, msize, msign), dst, is_bubble.
- dataM_out  out  memory_data_t  record to reg_MW dataM_in: result, pc, ctl, dst, is_bubble.
- stalldata  out  1  to reg_MW and the upstream registers; high holds upstream and bubbles reg_MW.
- dreq_valid  out  1  bus request valid.
- dreq_addr  out  AW  request address (byte address, unmodified).
- dreq_size  out  3  log2 access bytes.
- dreq_strobe  out  8  write byte enables; 0 for loads.
- dreq_data  out  XLEN  write data, lane-shifted.
- dresp_addr_ok  in  1  request accepted this cycle.
- dresp_data_ok  in  1  response/completion this cycle.
- dresp_data  in  XLEN  read data, naturally aligned 8-byte word.
- misalign  out  1  pulse: misaligned access detected.

Behaviour:
- Access present: `mem = !is_bubble && (memread || memwrite)`. Non-access records pass through combinationally with `result` = input result and `stalldata` = 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If `mem` is set and the address is aligned, `dreq_valid` = 1 combinationally.
  - `addr_ok && data_ok` -> complete this cycle, stay IDLE.
  - `addr_ok` only -> WAIT.
  - Neither -> REQ.
- REQ: `dreq_valid` = 1 with identical addr/size/strobe/data. `addr_ok` -> WAIT, or complete this cycle if `data_ok` is also high.
- WAIT: `dreq_valid` = 0. `data_ok` -> complete, go to IDLE.
- Request fields must not change while `dreq_valid` = 1 and `addr_ok` = 0. Upstream holds `dataE_in` stable while `stalldata` = 1.
- stalldata: `stalldata = mem && !complete`, combinational. Deasserts in the completion cycle so reg_MW captures the result on that edge.
- Completion-cycle `dataM_out.result`:
  - Loads: `dresp_data >> (8*addr[2:0])`, truncated to msize, then sign-extended (`msign`=1) or zero-extended to XLEN.
  - Stores: input result.
- Store lanes:
  - `strobe = ((1 << (1 << msize)) - 1) << addr[2:0]`.
  - `dreq_data = srcb << (8*addr[2:0])`.
  - msize 0..3 = 1/2/4/8 bytes.
- Misaligned (`addr mod (1<<msize)` ≠ 0):
  - No request issued; `misalign` = 1 for that cycle only.
  - Record passes with `result` = 0 and `is_bubble` = 1; `stalldata` = 0.
- Reset (`reset` = 0), including mid-transaction:
  - FSM -> IDLE.
  - `dreq_valid` = 0, `stalldata` = 0, `misalign` = 0.
  - `dataM_out.is_bubble` = 1, all other `dataM_out` fields 0.
  - The bus slave is reset by the same signal, so no response is expected afterwards.
- `data_ok` in IDLE with no outstanding access is ignored.
- Latency: 0 cycles with a same-cycle response; otherwise N cycles of stall, where N is the cycle count until `data_ok`.

Decomposition:
- Shared package `common`:
  - `msize_t` (3 bits) and MSIZE_B/H/W/D constants.
  - ctl fields memread, memwrite, msize, msign in `control_t`.
  - `execute_data_t` gains `srcb` if it does not already carry it.
  - `mem_state_t` enum {IDLE, REQ, WAIT}.
- Sub-module `mem_lane_ext`: purely combinational.
  - Inputs: addr[2:0], msize, msign, srcb, rdata.
  - Outputs: strobe, wdata, load value, misalign.
  - The FSM and handshake stay in `mem_access_stage`.

Test Plan:
- Same-cycle response: LD addr 0x80000010, `addr_ok=data_ok=1` in cycle 0, rdata 0x1122334455667788 -> `stalldata` stays 0; `result` = 0x1122334455667788; FSM stays IDLE.
- Delayed accept: SW addr 0x80000004, srcb 0xDEADBEEF, `addr_ok` at cycle 2, `data_ok` at cycle 4 -> `dreq_valid` high cycles 0-2 with strobe 0xF0 and data 0xDEADBEEF_00000000; `stalldata` high cycles 0-3, low in cycle 4.
- Sign extension: LB at addr offset 7, rdata 0x80xx..xx -> result 0xFFFFFFFFFFFFFF80. Same access as LBU -> 0x80.
- Misaligned: LW at addr 0x...02 -> no `dreq_valid`; `misalign` pulse; `dataM_out.is_bubble` = 1; `stalldata` = 0.
- Reset mid-operation: `reset`=0 while in WAIT -> next cycle IDLE, `stalldata` 0, `dreq_valid` 0; a later stray `data_ok` has no effect.
- Bubble input: `is_bubble`=1 with memread=1 -> no request; record passes through; `stalldata` 0.
